// File: rtl/wb_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_host_pkg
// Description : Shared types and constants for the Wishbone host master.
//               Holds the FSM state encoding, default bus widths and the
//               response-error encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_host_pkg;

  // Transfer FSM: wait for a command, run one bus cycle, hand back the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Default bus widths for instances that do not override them.
  localparam int ADDR_W_DEFAULT = 32;
  localparam int DATA_W_DEFAULT = 32;

  // Encoding of the rsp_err field.
  localparam logic RSP_ERR_OK   = 1'b0;
  localparam logic RSP_ERR_FAIL = 1'b1;

endpackage : wb_host_pkg
`default_nettype wire

// File: rtl/wb_host_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_host_master
// Description : Wishbone classic single-transfer master. Accepts one command
//               on a valid/ready stream, runs one bus cycle with a bounded
//               wait for ack/err, and returns read data and status on a
//               valid/ready response stream.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  // Command stream
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [DATA_W-1:0]   cmd_dat,
  input  logic [DATA_W/8-1:0] cmd_sel,
  // Response stream
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_dat,
  output logic                rsp_err,
  // Wishbone master port
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  input  logic [DATA_W-1:0]   wbm_dat_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Last wait cycle before abort, and the saturation ceiling of the counter.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t              state_q,   state_d;
  logic                cyc_q,     cyc_d;
  logic                we_q,      we_d;
  logic [ADDR_W-1:0]   adr_q,     adr_d;
  logic [DATA_W-1:0]   dat_q,     dat_d;
  logic [SEL_W-1:0]    sel_q,     sel_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;

  // Next-state and datapath: capture the command, watch ack/err/timeout,
  // then hold the result until the requester takes it.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cnt_d   = '0;
        end
      end

      BUS: begin
        // err wins over a simultaneous ack.
        if (wbm_err_i) begin
          state_d   = RESP;
          cyc_d     = 1'b0;
          rsp_err_d = RSP_ERR_FAIL;
          rsp_dat_d = '0;
        end else if (wbm_ack_i) begin
          state_d   = RESP;
          cyc_d     = 1'b0;
          rsp_err_d = RSP_ERR_OK;
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
        end else if (cnt_q == CNT_LAST) begin
          // No response from the slave within the allowed window.
          state_d   = RESP;
          cyc_d     = 1'b0;
          rsp_err_d = RSP_ERR_FAIL;
          rsp_dat_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;

endmodule : wb_host_master
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_host_master
// Description : Self-checking bench for wb_host_master. Directed commands,
//               a configurable Wishbone slave model, and a scoreboard whose
//               monitor checks each response handshake against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_host_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_adr = '0;
  logic [DATA_W-1:0] cmd_dat = '0;
  logic [3:0]        cmd_sel = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_dat;
  logic              rsp_err;
  logic              wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [3:0]        wbm_sel_o;
  logic              wbm_ack_i = 1'b0;
  logic              wbm_err_i = 1'b0;
  logic [DATA_W-1:0] wbm_dat_i = '0;

  wb_host_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic              err;
  } rsp_t;

  rsp_t exp_q[$];

  // Slave model configuration: 0 = silent, 1 = ack, 2 = err, 3 = ack+err.
  int                sl_mode  = 1;
  int                sl_delay = 0;
  int                sl_cnt   = 0;
  logic [DATA_W-1:0] sl_rdata = '0;

  // Expected bus contents for the transfer in flight.
  logic              exp_we  = 1'b0;
  logic [ADDR_W-1:0] exp_adr = '0;
  logic [DATA_W-1:0] exp_dat = '0;
  logic [3:0]        exp_sel = '0;
  int                cyc_cnt = 0;
  logic              stable_bad = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: responds in BUS cycle number sl_delay (0 = first cycle).
  always begin
    @(posedge clk);
    #1;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (sl_cnt == sl_delay && sl_mode != 0) begin
        wbm_ack_i = (sl_mode == 1 || sl_mode == 3);
        wbm_err_i = (sl_mode == 2 || sl_mode == 3);
      end else begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
      end
      wbm_dat_i = sl_rdata;
      sl_cnt++;
    end else begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      sl_cnt    = 0;
    end
  end

  // Bus observer: counts cycle length and flags any change of bus fields.
  always @(negedge clk) begin
    if (wbm_cyc_o) begin
      cyc_cnt++;
      if (wbm_stb_o !== 1'b1 || wbm_we_o !== exp_we || wbm_adr_o !== exp_adr ||
          wbm_dat_o !== exp_dat || wbm_sel_o !== exp_sel)
        stable_bad = 1'b1;
    end
  end

  // Scoreboard monitor: every response handshake is compared to the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got dat=0x%0h err=%0b expected no response", rsp_dat, rsp_err);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_dat", 64'(rsp_dat), 64'(e.dat));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic drive_cmd(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
  endtask

  // Waits for the command to be taken; optionally queues its expected response.
  task automatic wait_accept(input bit push, input logic [31:0] e_dat, input logic e_err);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    exp_we     = cmd_we;
    exp_adr    = cmd_adr;
    exp_dat    = cmd_dat;
    exp_sel    = cmd_sel;
    cyc_cnt    = 0;
    stable_bad = 1'b0;
    cmd_valid  = 1'b0;
    if (push) begin
      rsp_t e;
      e.dat = e_dat;
      e.err = e_err;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_rsp_done(input string name, input int exp_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rsp_seen"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    check({name, "_cyc_len"}, 64'(cyc_cnt), 64'(exp_cyc));
    check({name, "_stable"}, 64'(stable_bad), 64'(0));
  endtask

  task automatic xfer(input string name, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input int mode, input int delay, input logic [31:0] rdata,
                      input logic [31:0] e_dat, input logic e_err, input int e_cyc);
    sl_mode  = mode;
    sl_delay = delay;
    sl_rdata = rdata;
    drive_cmd(we, adr, dat, sel);
    wait_accept(1'b1, e_dat, e_err);
    wait_rsp_done(name, e_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_err",   64'(rsp_err),   64'(0));
    check("rst_rsp_dat",   64'(rsp_dat),   64'(0));
    check("rst_cyc",       64'(wbm_cyc_o), 64'(0));
    check("rst_stb",       64'(wbm_stb_o), 64'(0));
    check("rst_we",        64'(wbm_we_o),  64'(0));
    check("rst_adr",       64'(wbm_adr_o), 64'(0));
    check("rst_dat",       64'(wbm_dat_o), 64'(0));
    check("rst_sel",       64'(wbm_sel_o), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero-wait write: ack in first BUS cycle, write returns zero data.
    xfer("wr0", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'hFFFF_FFFF,
         32'h0, 1'b0, 1);
    // Wait-state read: ack after 3 wait cycles.
    xfer("rd3", 1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 3, 32'h0000_00A5,
         32'h0000_00A5, 1'b0, 4);
    // Timeout: silent slave, cycle lasts exactly TIMEOUT cycles.
    xfer("tmo", 1'b0, 32'h3000_000C, 32'h0, 4'hF, 0, 0, 32'h1234_5678,
         32'h0, 1'b1, TIMEOUT);
    // Error precedence: ack and err together on a read after one wait cycle.
    xfer("ackerr", 1'b0, 32'h3000_0010, 32'h0, 4'h3, 3, 1, 32'hCAFE_F00D,
         32'h0, 1'b1, 2);
    // Error alone on a write.
    xfer("err", 1'b1, 32'h3000_0014, 32'h5555_AAAA, 4'h1, 2, 0, 32'h0,
         32'h0, 1'b1, 1);
    // Zero-wait read with a different data pattern.
    xfer("rd0", 1'b0, 32'h3000_0018, 32'h0, 4'hC, 1, 0, 32'h8001_7FFE,
         32'h8001_7FFE, 1'b0, 1);

    // Backpressure: response held while a second command waits.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    sl_mode   = 1;
    sl_delay  = 0;
    sl_rdata  = 32'h5A5A_0001;
    drive_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    wait_accept(1'b1, 32'h5A5A_0001, 1'b0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rsp_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("bp_rsp_valid_seen", 64'(seen), 64'(1));
    end
    check("bp_cyc_len", 64'(cyc_cnt), 64'(1));
    drive_cmd(1'b1, 32'h3000_0024, 32'h1122_3344, 4'h3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      check("bp_rsp_dat",   64'(rsp_dat),   64'(32'h5A5A_0001));
      check("bp_rsp_err",   64'(rsp_err),   64'(0));
      check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
      check("bp_no_cyc",    64'(wbm_cyc_o), 64'(0));
    end
    check("bp_queue_held", 64'(exp_q.size()), 64'(1));
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_accept(1'b1, 32'h0, 1'b0);
    wait_rsp_done("bp_wr", 1);

    // Reset in the middle of a waiting bus cycle.
    sl_mode = 0;
    drive_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    wait_accept(1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    check("mid_cyc_before", 64'(wbm_cyc_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_cyc",       64'(wbm_cyc_o), 64'(0));
    check("mid_rst_stb",       64'(wbm_stb_o), 64'(0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      bit any_rsp = 1'b0;
      bit any_cyc = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (rsp_valid) any_rsp = 1'b1;
        if (wbm_cyc_o) any_cyc = 1'b1;
      end
      check("post_rst_no_rsp", 64'(any_rsp), 64'(0));
      check("post_rst_no_cyc", 64'(any_cyc), 64'(0));
      check("post_rst_ready",  64'(cmd_ready), 64'(1));
    end

    // Master still works after the aborted transfer.
    xfer("post_rd", 1'b0, 32'h3000_0034, 32'h0, 4'hF, 1, 2, 32'h0BAD_C0DE,
         32'h0BAD_C0DE, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_wb_host_master
`default_nettype wire

// File: doc/wb_host_master.md
# wb_host_master

Wishbone classic single-transfer master that turns a valid/ready command stream into bus cycles and returns read data and status on a valid/ready response stream. It is the initiator counterpart to the user project's Wishbone slave port. It lets on-chip logic (LA- or IO-driven test sequencers) exercise the slave without the management SoC. Includes a bus timeout, so a missing acknowledge cannot hang the requester.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-select width is DATA_W/8
- TIMEOUT, 255, max cycles waiting for ack/err before abort; must be ≥ 1

Ports:
- wb_clk_i  in  1  clock, all state updates on rising edge
- wb_rst_ni  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  ADDR_W  byte address
- cmd_dat  in  DATA_W  write data
- cmd_sel  in  DATA_W/8  byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester takes the response
- rsp_dat  out  DATA_W  read data; 0 for writes and on error
- rsp_err  out  1  1 = bus error or timeout
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone cycle, strobe and write-enable
- wbm_adr_o  out  ADDR_W  address
- wbm_dat_o  out  DATA_W  write data
- wbm_sel_o  out  DATA_W/8  byte selects
- wbm_ack_i, wbm_err_i  in  1 each  slave acknowledge and error
- wbm_dat_i  in  DATA_W  slave read data

## Operation
- FSM states IDLE, BUS, RESP; reset state IDLE.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid, register we/adr/dat/sel, clear the timeout counter and go to BUS.
- **BUS**
  - wbm_cyc_o = wbm_stb_o = 1; all wbm_* outputs come from registers and stay stable for the whole cycle.
  - ack or err is sampled each edge.
  - err (including err and ack in the same cycle): rsp_err = 1, rsp_dat = 0, go to RESP.
  - ack alone: rsp_err = 0; rsp_dat = wbm_dat_i for reads, 0 for writes; go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT−1 with no ack/err, abort: rsp_err = 1, rsp_dat = 0, go to RESP.
- **RESP**
  - rsp_valid = 1; rsp_dat and rsp_err are held stable.
  - On rsp_ready, go to IDLE.
- cmd_ready = 0 in BUS and RESP. At most one outstanding transfer.
- The counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Any ack/err arriving outside BUS is ignored.

## Timing
- Reset values: cmd_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_dat = 0, all wbm_* = 0.
- Asynchronous reset mid-transfer drops wbm_cyc_o/wbm_stb_o immediately. No response is produced for the aborted command.
- Command accepted at edge N → wbm_cyc_o/wbm_stb_o high in cycle N+1.
- ack first seen at edge M → cyc/stb low and rsp_valid high from M onward.
- Minimum latency with a zero-wait slave: accept at edge 0, ack sampled at edge 1, rsp_valid visible in cycle 1–2. Three edges per transfer including the response handshake.
- Timeout: cyc/stb stay high for exactly TIMEOUT cycles, then drop in the same edge that raises rsp_valid.
- rsp_valid held indefinitely while rsp_ready = 0. There is no back-to-back bypass: the next command is accepted no earlier than the cycle after the response handshake.

## Structure
- Shared package wb_host_pkg holds:
  - the state enum (IDLE/BUS/RESP);
  - defaults for ADDR_W/DATA_W;
  - the response-error encoding constant.
- Single module; no sub-module needed. The timeout counter is inline.

## Test plan
- Zero-wait write: cmd adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave acks in the first BUS cycle → wbm_we_o = 1, dat/adr match, rsp_valid with rsp_err = 0 and rsp_dat = 0; cyc high exactly 1 cycle.
- Wait-state read: slave acks after 3 cycles with dat=0x0000_00A5 → cyc/stb high 4 cycles, inputs stable throughout, rsp_dat = 0xA5.
- Timeout: TIMEOUT = 8, slave never acks → cyc high exactly 8 cycles, then rsp_err = 1 and rsp_dat = 0.
- Error precedence: ack and err asserted together on a read → rsp_err = 1, rsp_dat = 0.
- Backpressure: rsp_ready held low 5 cycles → rsp_valid and rsp_dat stable, cmd_ready = 0 and a pending cmd_valid not accepted; the command is accepted after the handshake.
- Reset mid-BUS: deassert wb_rst_ni during wait states → cyc/stb low immediately, cmd_ready = 1, no rsp_valid after reset release.
